// File: rtl/issue_execute_fifo_if.sv
// Shared entry type plus the issue->execute FIFO interface.
//   issue_execute_pkg    : issue_execute_pack_t, the entry carried from issue to execute
//   issue_execute_fifo_if: push/data_in/pop/flush from the pipeline (master),
//                          full/count/data_out/data_out_valid from the FIFO (slave)
package issue_execute_pkg;
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } issue_execute_pack_t;
endpackage

interface issue_execute_fifo_if #(parameter int DEPTH = 4);
  import issue_execute_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);

  logic                flush;
  logic                push;
  issue_execute_pack_t data_in;
  logic                full;
  logic [CW-1:0]       count;
  issue_execute_pack_t data_out;
  logic                data_out_valid;
  logic                pop;

  modport master (output flush, push, data_in, pop,
                  input  full, count, data_out, data_out_valid);
  modport slave  (input  flush, push, data_in, pop,
                  output full, count, data_out, data_out_valid);
endinterface

// File: rtl/issue_execute_fifo.sv
// Show-ahead FIFO between the issue stage and one execute unit.
//   clk, rst : clock, synchronous active-high reset
//   io       : issue_execute_fifo_if.slave
//              push/data_in enqueue, pop consumes the presented head,
//              flush empties the queue and beats push/pop,
//              full/count are registered occupancy, data_out is the head
//              (all-zero when data_out_valid is low).
// Optional: ISSUE_EXECUTE_FIFO_BYPASS_EN lets a push into an empty queue be
// presented combinationally the same cycle; if it is also popped it is never
// stored.
module issue_execute_fifo
  import issue_execute_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  issue_execute_fifo_if.slave   io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  issue_execute_pack_t mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] cnt;

  logic empty, push_ok, pop_ok, byp, byp_pop, wr_en, rd_en;

  assign empty   = (cnt == '0);
  assign io.full = (cnt == CW'(DEPTH));
  assign io.count = cnt;

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  assign byp = empty & io.push & ~io.flush;
`else
  assign byp = 1'b0;
`endif

  assign io.data_out_valid = ~empty | byp;

  always_comb begin
    io.data_out = '0;
    if (!empty)   io.data_out = mem[rptr];
    else if (byp) io.data_out = io.data_in;
  end

  // Acceptance only looks at registered full: a pop cannot make room for a
  // push in the same cycle.
  assign push_ok = io.push & ~io.full & ~io.flush;
  assign pop_ok  = io.pop & io.data_out_valid & ~io.flush;

  // Bypassed entry consumed in flight: neither stored nor counted.
  assign byp_pop = byp & io.pop;
  assign wr_en   = push_ok & ~byp_pop;
  assign rd_en   = pop_ok & ~byp_pop;

  always_ff @(posedge clk) begin
    if (rst || io.flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; contents are qualified by cnt.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wptr] <= io.data_in;
  end
endmodule

// File: tb/tb_issue_execute_fifo.sv
module tb_issue_execute_fifo;
  import issue_execute_pkg::*;
  localparam int DEPTH = 4;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_execute_fifo_if #(.DEPTH(DEPTH)) bus ();
  issue_execute_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(bus));

  issue_execute_pack_t exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic issue_execute_pack_t mk(input int id);
    issue_execute_pack_t e;
    e.rob_id = 6'(id);
    e.opcode = 4'(id * 3 + 1);
    e.rd     = 5'(id ^ 5'h15);
    e.src_a  = 32'(id) * 32'h01010101 ^ 32'hA5A5_0000;
    e.src_b  = ~(32'(id) << 4);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs mid-cycle against the scoreboard, clock,
  // then update the scoreboard.
  task automatic cycle(input bit p, input int id, input bit q, input bit f, input bit r);
    int  sz;
    bit  byp;
    issue_execute_pack_t ed;
    rst = r; bus.push = p; bus.data_in = mk(id); bus.pop = q; bus.flush = f;
    sz  = exp_q.size();
    byp = BYP && p && !f && sz == 0;
    ed  = (sz != 0) ? exp_q[0] : (byp ? mk(id) : '0);
    @(negedge clk);
    if (!r) begin
      chk("count", 80'(bus.count), 80'(sz));
      chk("full", 80'(bus.full), 80'(sz == DEPTH));
      chk("valid", 80'(bus.data_out_valid), 80'(sz != 0 || byp));
      chk("data_out", 80'(bus.data_out), 80'(ed));
    end
    @(posedge clk);
    #1;
    if (r || f) exp_q.delete();
    else if (!(byp && q)) begin
      if (q && sz > 0) void'(exp_q.pop_front());
      if (p && sz < DEPTH) exp_q.push_back(mk(id));
    end
  endtask

  initial begin
    rst = 1'b1; bus.push = 0; bus.pop = 0; bus.flush = 0; bus.data_in = '0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);                       // reset state
    cycle(0, 0, 0, 0, 0);

    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0);
    cycle(1, 5, 0, 0, 0);                       // dropped while full
    cycle(1, 6, 1, 0, 0);                       // full: push ignored even with pop
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);                       // pop while empty
    cycle(0, 0, 0, 0, 0);

    cycle(1, 10, 0, 0, 0);                      // hold one entry
    for (int i = 11; i <= 20; i++) cycle(1, i, 1, 0, 0);  // wrap, count stays 1
    cycle(0, 0, 1, 0, 0);

    for (int i = 30; i < 33; i++) cycle(1, i, 0, 0, 0);
    cycle(1, 33, 1, 1, 0);                      // flush beats push and pop
    cycle(0, 0, 0, 0, 0);

    cycle(1, 7, 1, 0, 0);                       // bypass case when enabled
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);

    for (int i = 40; i < 43; i++) cycle(1, i, 0, 0, 0);
    cycle(1, 43, 0, 0, 1);                      // reset mid-stream
    cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++)
      cycle(bit'($urandom_range(0, 1)), 50 + i, bit'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_execute_fifo.md
# issue_execute_fifo

- Buffers issue_execute_pack_t entries between the issue stage (writer) and one execute unit (reader, e.g. execute_mul or execute_alu).
- The read side is show-ahead: the head entry is always presented; the execute unit consumes it with a single-cycle pop.
- A commit-driven flush empties the queue.
- One instance sits in front of each execute unit.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush (commit_feedback_pack.enable & commit_feedback_pack.flush, combined by the parent).
- push  in  1  writer requests enqueue of data_in.
- data_in  in  issue_execute_pack_t  entry to enqueue.
- full  out  1  no free entry; registered state.
- count  out  $clog2(DEPTH+1)  current occupancy.
- data_out  out  issue_execute_pack_t  head entry.
- data_out_valid  out  1  head entry present.
- pop  in  1  reader consumes head this cycle.

## Operation
State:
- storage array of DEPTH entries.
- rptr, wptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
- count: 0..DEPTH.

Derived signals:
- push_ok = push & !full & !flush.
- pop_ok = pop & data_out_valid & !flush.

Per rising edge:
- rst: rptr = wptr = count = 0; storage contents need not be reset.
- else if flush: rptr = wptr = count = 0. Flush beats push and pop; the pushed entry is discarded.
- else:
  - push_ok: storage[wptr] = data_in; wptr += 1.
  - pop_ok: rptr += 1.
  - count += push_ok − pop_ok.
  - Simultaneous push_ok and pop_ok leaves count unchanged.

Outputs:
- full = (count == DEPTH).
- data_out_valid = (count != 0).
- data_out = storage[rptr] when data_out_valid, otherwise all-zero.

Boundary conditions:
- Push while full: ignored, even when pop is asserted the same cycle. Acceptance is decided only by the registered full; there is no comb path from pop to full.
- Pop while empty: ignored; no pointer movement.
- Pointer wrap: DEPTH−1 → 0 with no bubble.
- rst or flush mid-stream: all held entries are lost; outputs read empty on the next cycle.

## Timing
- Enqueue-to-visible latency: 1 cycle. An entry pushed at edge N appears on data_out after edge N with data_out_valid = 1.
- Pop takes effect at the edge. The next entry, if any, is presented immediately after that edge.
- Sustained throughput: 1 push and 1 pop per cycle.
- Outputs after reset: full = 0, count = 0, data_out_valid = 0, data_out = 0.
- Flush asserted during cycle N: outputs read empty after edge N.

## Configuration
Macro ISSUE_EXECUTE_FIFO_BYPASS_EN.

Defined (bypass):
- When count == 0 and push & !flush: data_out = data_in and data_out_valid = 1 combinationally in the same cycle.
- If pop is also asserted that cycle, the entry is consumed directly and not stored; count stays 0.
- If pop is not asserted, the entry is stored normally.
- Bypass never applies while flush is high.

Undefined:
- Pure registered behaviour; minimum latency is 1 cycle as stated under Timing.

## Test plan
- Reset, then hold 2 cycles → full = 0, count = 0, data_out_valid = 0, data_out = 0.
- Push rob_id 1, 2, 3, 4 on consecutive cycles with pop = 0, DEPTH = 4 → count = 4 and full = 1. A 5th push of rob_id 5 is dropped; count stays 4; head rob_id = 1.
- From full, pop 4 cycles → data_out rob_id sequence 1, 2, 3, 4, then data_out_valid = 0. A further pop is ignored; count stays 0.
- Continuous push + pop for 10 cycles starting with 1 entry held (pointer wrap) → count stays 1; rob_ids leave in push order with no gap.
- Hold 3 entries, assert flush together with push and pop → after the edge count = 0 and data_out_valid = 0; the pushed entry is absent.
- ISSUE_EXECUTE_FIFO_BYPASS_EN defined, empty queue, push rob_id 7 with pop = 1 → same cycle data_out.rob_id = 7 and data_out_valid = 1; after the edge count = 0. Without the macro, data_out_valid = 0 that cycle and count = 1 after the edge.
